regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port register file for the pipelined/superscalar RISC-V cores. Provides NRD async read
//  ports and NWR sync write ports, plus optional write-to-read bypass and a per-register busy scoreboard for hazard detection.
//  Contents are cleared by a post-reset sequencer. Replaces the fixed 2R/1W file in the datapath.
// PARAMETERS
//  XLEN    32  data width in bits
//  NREGS   32  number of registers, power of 2 and >=2; AW = $clog2(NREGS)
//  NRD     2   read ports
//  NWR     1   write ports, 1..4
//  BYPASS  0   1: a read of an address written this cycle returns the incoming write data
// PORTS
//  clk         in   1            clock, all state updates on posedge
//  rst         in   1            synchronous reset, active-high
//  rd_addr     in   NRD x AW     read addresses
//  rd_data     out  NRD x XLEN   read data (combinational)
//  rd_busy     out  NRD          scoreboard busy bit of rd_addr[i]
//  wr_en       in   NWR          write enables
//  wr_addr     in   NWR x AW     write addresses
//  wr_data     in   NWR x XLEN   write data
//  iss_en      in   1            mark iss_addr busy (producer issued)
//  iss_addr    in   AW           destination register of the issued producer
//  ready       out  1            1 = clear sequence done, file usable
// BEHAVIOUR
//  - Entry 0 is hardwired to zero. Reads of address 0 return 0. Writes to address 0 are dropped. Entry 0 is never busy.
//  - FSM states are INIT and RUN. While rst=1: state<=INIT, cnt<=1, all busy bits<=0, ready=0.
//  - INIT: each cycle writes 0 to entry cnt and increments cnt. After writing entry NREGS-1, state<=RUN.
//    ready is a registered output. It rises on the edge that enters RUN, NREGS-1 cycles after rst falls.
//  - In INIT: wr_en and iss_en are ignored, rd_data=0, rd_busy=0.
//  - rst asserted mid-INIT or in RUN restarts the full clear sequence. Any data in flight is discarded.
//  - RUN write: on posedge, for each port p with wr_en[p] and wr_addr[p]!=0, entry <= wr_data[p].
//    If several ports hit the same address in one cycle, the highest port index wins.
//  - Read, BYPASS=0: rd_data[i] = stored entry. The new value is visible in the cycle after the write edge.
//  - Read, BYPASS=1: if any enabled port writes rd_addr[i]!=0 this cycle, rd_data[i] = wr_data of the
//    highest such port. Otherwise rd_data[i] = stored entry.
//  - Scoreboard, RUN only:
//    - An enabled write to address a clears busy[a].
//    - iss_en sets busy[iss_addr] when iss_addr!=0.
//    - If set and clear hit the same address in one cycle, set wins (new producer overrides).
//    - rd_busy[i] = busy[rd_addr[i]], registered state only, no bypass.
//      With BYPASS=1 the datapath may still forward wr_data in the write cycle.
//  - Arithmetic: cnt is AW bits wide and is compared to NREGS-1, so there is no wrap. No other arithmetic.
//  - rd_data and rd_busy are combinational from state and inputs. ready and the busy bits reset to 0.
// STRUCTURE
//  - Package regfile_pkg: typedef rf_state_e {RF_INIT, RF_RUN}; localparam helper for AW.
//    Shared with the hazard unit.
//  - Sub-module regfile_scoreboard (NREGS, NWR, NRD): busy vector, set/clear priority, rd_busy lookup.
//  - Storage, write-priority mux, bypass mux and the INIT/RUN FSM stay in regfile_mp.
//    Storage is written with generate loops over NWR and NRD.
// TESTING (default XLEN=32, NREGS=32; NWR=2, BYPASS=1 unless stated)
//  1. Reset and clear:
//     - Pulse rst for 1 cycle -> ready=0 for exactly 31 cycles, then 1.
//     - Afterwards every rd_data reads 0.
//     - Re-assert rst at cycle 10 of INIT -> the 31-cycle count restarts.
//  2. Write/read:
//     - wr_en[0], x5 <= 0xDEADBEEF -> rd_addr[0]=5 returns 0xDEADBEEF in the same cycle (bypass).
//     - The stored value persists afterwards.
//     - With BYPASS=0, the same cycle returns the old value 0.
//  3. x0 protection:
//     - Write 0x1234 to x0 -> reads 0.
//     - iss_en with iss_addr=0 -> rd_busy=0.
//  4. Port conflict:
//     - Port 0 writes x7=0x11 and port 1 writes x7=0x22 in one cycle -> x7 reads 0x22, both same cycle and after.
//  5. Scoreboard:
//     - iss x9 -> rd_busy=1 from the next cycle.
//     - Write x9 -> busy clears after the edge.
//     - iss x9 and write x9 in the same cycle -> busy stays 1.
//  6. INIT lockout:
//     - wr_en and iss_en asserted during INIT -> no effect.
//     - After ready, all regs read 0 and all busy bits are 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types for the multi-port register file and the hazard unit.
// rf_aw derives the register address width from the register count.
package regfile_pkg;

  typedef enum logic {
    RF_INIT,
    RF_RUN
  } rf_state_e;

  function automatic int rf_aw(input int nregs);
    return (nregs < 2) ? 1 : $clog2(nregs);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: issue sets, write clears, and issue wins a same-cycle collision.
// Lookups see registered state only, so a write is never bypassed into rd_busy.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int NWR   = 1,
  parameter int NRD   = 2,
  localparam int AW   = rf_aw(NREGS)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_run,
  input  logic [NWR-1:0]          i_wr_en,
  input  logic [NWR-1:0][AW-1:0]  i_wr_addr,
  input  logic                    i_iss_en,
  input  logic [AW-1:0]           i_iss_addr,
  input  logic [NRD-1:0][AW-1:0]  i_rd_addr,
  output logic [NRD-1:0]          o_rd_busy
);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_nxt;

  // Clears first, then the set, so a new producer overrides a retiring one.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int p = 0; p < NWR; p++) begin
      if (i_wr_en[p]) w_busy_nxt[i_wr_addr[p]] = 1'b0;
    end
    if (i_iss_en && (i_iss_addr != '0)) w_busy_nxt[i_iss_addr] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy <= '0;
    end else if (i_run) begin
      r_busy <= w_busy_nxt;
    end
  end

  always_comb begin
    o_rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      o_rd_busy[i] = i_run & r_busy[i_rd_addr[i]];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with optional write-to-read bypass and a busy scoreboard.
// A post-reset sequencer walks entries 1..NREGS-1 writing zero before raising ready.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter int BYPASS = 0,
  localparam int AW    = rf_aw(NREGS)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NRD-1:0][AW-1:0]    i_rd_addr,
  output logic [NRD-1:0][XLEN-1:0]  o_rd_data,
  output logic [NRD-1:0]            o_rd_busy,
  input  logic [NWR-1:0]            i_wr_en,
  input  logic [NWR-1:0][AW-1:0]    i_wr_addr,
  input  logic [NWR-1:0][XLEN-1:0]  i_wr_data,
  input  logic                      i_iss_en,
  input  logic [AW-1:0]             i_iss_addr,
  output logic                      o_ready
);

  rf_state_e       r_state, w_state_nxt;
  logic [AW-1:0]   r_cnt, w_cnt_nxt;
  logic            r_ready, w_ready_nxt;
  logic            w_run;
  logic [XLEN-1:0] w_mem [NREGS];

  assign w_run   = (r_state == RF_RUN);
  assign o_ready = r_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= RF_INIT;
      r_cnt   <= AW'(1);
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ready <= w_ready_nxt;
    end
  end

  // cnt holds at NREGS-1 when the sweep finishes instead of wrapping.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      RF_INIT: begin
        if (r_cnt == AW'(NREGS - 1)) w_state_nxt = RF_RUN;
        else                         w_cnt_nxt   = r_cnt + AW'(1);
      end
      default: ;
    endcase
    w_ready_nxt = (w_state_nxt == RF_RUN);
  end

  assign w_mem[0] = '0;

  for (genvar r = 1; r < NREGS; r++) begin : g_reg
    logic [XLEN-1:0] r_q;
    logic            w_hit;
    logic [XLEN-1:0] w_val;

    // Later ports overwrite earlier ones, so the highest port index wins.
    always_comb begin
      w_hit = 1'b0;
      w_val = '0;
      for (int p = 0; p < NWR; p++) begin
        if (i_wr_en[p] && (i_wr_addr[p] == AW'(r))) begin
          w_hit = 1'b1;
          w_val = i_wr_data[p];
        end
      end
    end

    always_ff @(posedge i_clk) begin
      if (!i_rst) begin
        if (r_state == RF_INIT) begin
          if (r_cnt == AW'(r)) r_q <= '0;
        end else if (w_hit) begin
          r_q <= w_val;
        end
      end
    end

    assign w_mem[r] = r_q;
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic            w_bp_hit;
    logic [XLEN-1:0] w_bp_val;
    logic [XLEN-1:0] w_data;

    always_comb begin
      w_bp_hit = 1'b0;
      w_bp_val = '0;
      for (int p = 0; p < NWR; p++) begin
        if ((BYPASS != 0) && i_wr_en[p] && (i_wr_addr[p] == i_rd_addr[i]) &&
            (i_rd_addr[i] != '0)) begin
          w_bp_hit = 1'b1;
          w_bp_val = i_wr_data[p];
        end
      end
      if (!w_run)        w_data = '0;
      else if (w_bp_hit) w_data = w_bp_val;
      else               w_data = w_mem[i_rd_addr[i]];
    end

    assign o_rd_data[i] = w_data;
  end

  regfile_scoreboard #(
    .NREGS(NREGS),
    .NWR  (NWR),
    .NRD  (NRD)
  ) u_scoreboard (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_run     (w_run),
    .i_wr_en   (i_wr_en),
    .i_wr_addr (i_wr_addr),
    .i_iss_en  (i_iss_en),
    .i_iss_addr(i_iss_addr),
    .i_rd_addr (i_rd_addr),
    .o_rd_busy (o_rd_busy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: a bypassing 2W instance and a non-bypassing twin share stimulus.
// Stimulus pushes expected outputs; a negedge monitor pops and compares them.
module tb_regfile_mp;

  typedef enum int {K_RD0, K_RD1, K_BUSY0, K_BUSY1, K_READY, K_NBRD0} kind_e;

  typedef struct {
    kind_e       kind;
    string       name;
    logic [31:0] value;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0][4:0]  rdAddr = '0;
  logic [1:0][31:0] rdData;
  logic [1:0][31:0] nbRdData;
  logic [1:0]       rdBusy;
  logic [1:0]       nbRdBusy;
  logic [1:0]       wrEn = '0;
  logic [1:0][4:0]  wrAddr = '0;
  logic [1:0][31:0] wrData = '0;
  logic             issEn = 1'b0;
  logic [4:0]       issAddr = '0;
  logic             ready;
  logic             nbReady;

  exp_t expQ[$];
  int   vectorsApplied = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_rd_addr(rdAddr), .o_rd_data(rdData), .o_rd_busy(rdBusy),
    .i_wr_en(wrEn), .i_wr_addr(wrAddr), .i_wr_data(wrData), .i_iss_en(issEn),
    .i_iss_addr(issAddr), .o_ready(ready)
  );

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(0)) u_dut_nb (
    .i_clk(clk), .i_rst(rst), .i_rd_addr(rdAddr), .o_rd_data(nbRdData), .o_rd_busy(nbRdBusy),
    .i_wr_en(wrEn), .i_wr_addr(wrAddr), .i_wr_data(wrData), .i_iss_en(issEn),
    .i_iss_addr(issAddr), .o_ready(nbReady)
  );

  task automatic checkOutput(input exp_t e);
    logic [31:0] actual;
    case (e.kind)
      K_RD0:   actual = rdData[0];
      K_RD1:   actual = rdData[1];
      K_BUSY0: actual = {31'd0, rdBusy[0]};
      K_BUSY1: actual = {31'd0, rdBusy[1]};
      K_READY: actual = {31'd0, ready};
      default: actual = nbRdData[0];
    endcase
    vectorsApplied++;
    if (actual !== e.value) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", e.name, actual, e.value, $time);
    end
  endtask

  // Monitor: outputs are combinational/registered, so every queued expectation is due at the next negedge.
  always @(negedge clk) begin
    while (expQ.size() > 0) checkOutput(expQ.pop_front());
  end

  task automatic expectOut(input kind_e kind, input string name, input logic [31:0] value);
    exp_t e;
    e.kind  = kind;
    e.name  = name;
    e.value = value;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic [4:0] ra0, input logic [4:0] ra1, input logic [1:0] we,
                               input logic [4:0] wa0, input logic [31:0] wd0,
                               input logic [4:0] wa1, input logic [31:0] wd1,
                               input logic ie, input logic [4:0] ia);
    rdAddr[0] = ra0;
    rdAddr[1] = ra1;
    wrEn      = we;
    wrAddr[0] = wa0;
    wrData[0] = wd0;
    wrAddr[1] = wa1;
    wrData[1] = wd1;
    issEn     = ie;
    issAddr   = ia;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [4:0] ra0, input logic [4:0] ra1);
    applyStimulus(ra0, ra1, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: run did not complete, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset pulse; writes and issues held active through INIT must be ignored.
    idle(5'd3, 5'd4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    applyStimulus(5'd3, 5'd4, 2'b11, 5'd3, 32'hAAAA_0003, 5'd4, 32'hBBBB_0004, 1'b1, 5'd3);
    for (int k = 0; k < 31; k++) begin
      expectOut(K_READY, "ready_low_init", 32'd0);
      if (k % 10 == 0) begin
        expectOut(K_RD0, "init_rd_zero", 32'd0);
        expectOut(K_BUSY0, "init_busy_zero", 32'd0);
      end
      step();
    end
    idle(5'd0, 5'd0);
    expectOut(K_READY, "ready_high", 32'd1);

    for (int a = 0; a < 32; a++) begin
      idle(5'(a), 5'(31 - a));
      expectOut(K_RD0, "clear_rd0", 32'd0);
      expectOut(K_RD1, "clear_rd1", 32'd0);
      expectOut(K_BUSY0, "clear_busy0", 32'd0);
      expectOut(K_BUSY1, "clear_busy1", 32'd0);
      step();
    end

    // Write x5 with same-cycle bypass vs. non-bypass twin.
    applyStimulus(5'd5, 5'd0, 2'b01, 5'd5, 32'hDEAD_BEEF, 5'd0, 32'd0, 1'b0, 5'd0);
    expectOut(K_RD0, "bypass_x5", 32'hDEAD_BEEF);
    expectOut(K_NBRD0, "nobypass_x5_old", 32'd0);
    step();
    idle(5'd5, 5'd0);
    expectOut(K_RD0, "stored_x5", 32'hDEAD_BEEF);
    expectOut(K_NBRD0, "nobypass_x5_new", 32'hDEAD_BEEF);
    step();

    // x0 stays zero and never busy.
    applyStimulus(5'd0, 5'd0, 2'b01, 5'd0, 32'h0000_1234, 5'd0, 32'd0, 1'b0, 5'd0);
    expectOut(K_RD0, "x0_bypass", 32'd0);
    step();
    applyStimulus(5'd0, 5'd0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd0);
    expectOut(K_RD0, "x0_stored", 32'd0);
    step();
    idle(5'd0, 5'd0);
    expectOut(K_BUSY0, "x0_busy", 32'd0);
    step();

    // Port conflict on x7: port 1 wins.
    applyStimulus(5'd7, 5'd0, 2'b11, 5'd7, 32'h11, 5'd7, 32'h22, 1'b0, 5'd0);
    expectOut(K_RD0, "conflict_bypass", 32'h22);
    expectOut(K_NBRD0, "conflict_nb_old", 32'd0);
    step();
    idle(5'd7, 5'd5);
    expectOut(K_RD0, "conflict_stored", 32'h22);
    expectOut(K_NBRD0, "conflict_nb_new", 32'h22);
    expectOut(K_RD1, "x5_persists", 32'hDEAD_BEEF);
    step();

    // Scoreboard: issue, retire, then issue and retire together.
    applyStimulus(5'd9, 5'd9, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd9);
    expectOut(K_BUSY0, "iss_same_cycle", 32'd0);
    step();
    idle(5'd9, 5'd9);
    expectOut(K_BUSY0, "iss_busy0", 32'd1);
    expectOut(K_BUSY1, "iss_busy1", 32'd1);
    expectOut(K_RD0, "x9_before", 32'd0);
    step();
    applyStimulus(5'd9, 5'd9, 2'b10, 5'd0, 32'd0, 5'd9, 32'h99, 1'b0, 5'd0);
    expectOut(K_BUSY0, "wr_busy_no_bypass", 32'd1);
    expectOut(K_RD0, "x9_bypass", 32'h99);
    step();
    idle(5'd9, 5'd9);
    expectOut(K_BUSY0, "wr_clears_busy", 32'd0);
    expectOut(K_RD1, "x9_stored", 32'h99);
    step();
    applyStimulus(5'd9, 5'd9, 2'b01, 5'd9, 32'hAA, 5'd0, 32'd0, 1'b1, 5'd9);
    step();
    idle(5'd9, 5'd9);
    expectOut(K_BUSY0, "set_wins", 32'd1);
    expectOut(K_RD0, "x9_reissue_data", 32'hAA);
    step();

    // Reset in RUN, then reset again mid-INIT: the full count restarts.
    rst = 1'b1;
    step();
    rst = 1'b0;
    expectOut(K_READY, "rst_run_ready", 32'd0);
    expectOut(K_BUSY0, "rst_run_busy", 32'd0);
    expectOut(K_RD0, "rst_run_rd", 32'd0);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) expectOut(K_READY, "ready_low_partial", 32'd0);
      step();
    end
    rst = 1'b1;
    expectOut(K_READY, "ready_low_rerst", 32'd0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 31; k++) begin
      expectOut(K_READY, "ready_low_restart", 32'd0);
      step();
    end
    expectOut(K_READY, "ready_high_restart", 32'd1);
    step();
    idle(5'd5, 5'd7);
    expectOut(K_RD0, "x5_cleared", 32'd0);
    expectOut(K_RD1, "x7_cleared", 32'd0);
    step();
    idle(5'd9, 5'd9);
    expectOut(K_RD0, "x9_cleared", 32'd0);
    expectOut(K_BUSY0, "x9_busy_cleared", 32'd0);
    step();

    step();
    if (expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
